// File: rtl/seg_rx_port_scheduler_pkg.sv
// rtl/seg_rx_port_scheduler_pkg.sv - shared FSM encoding and round-robin select for the RX port scheduler
// Purpose: state encoding for the frame arbiter and the priority-select function
// used to pick the next granted port. Ports: none (package).
package seg_rx_port_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_t;

  localparam int MAX_PORTS = 8;

  // First set bit of req at or after ptr, ascending and wrapping within n_ports.
  // Walking the offsets from the far end down lets the nearest requester win.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int n_ports);
    logic [2:0] pick;
    int idx;
    pick = '0;
    for (int k = MAX_PORTS - 1; k >= 0; k--) begin
      if (k < n_ports) begin
        idx = (int'(ptr) + k) % n_ports;
        if (req[idx[2:0]]) pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/seg_arb_skid.sv
// rtl/seg_arb_skid.sv - two-entry register/skid output stage for the merged stream
// Purpose: fully registered stream stage; in_tready comes from a register so
// the downstream ready never reaches the upstream ready combinationally.
// Ports: clk/rst; in_* beat plus in_tvalid/in_tready; out_* beat plus
// out_tvalid/out_tready.
module seg_arb_skid #(
  parameter int DATA_WIDTH = 1024,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic [KEEP_WIDTH-1:0] in_tkeep,
  input  logic                  in_tlast,
  input  logic                  in_tuser,
  input  logic [ID_WIDTH-1:0]   in_tid,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic [KEEP_WIDTH-1:0] out_tkeep,
  output logic                  out_tlast,
  output logic                  out_tuser,
  output logic [ID_WIDTH-1:0]   out_tid,
  output logic                  out_tvalid,
  input  logic                  out_tready
);

  localparam int W = DATA_WIDTH + KEEP_WIDTH + 2 + ID_WIDTH;

  logic [W-1:0] in_bus;
  logic [W-1:0] out_bus;
  logic [W-1:0] skid_bus;
  logic         out_valid;
  logic         skid_valid;

  assign in_bus    = {in_tdata, in_tkeep, in_tlast, in_tuser, in_tid};
  assign in_tready = ~skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_bus    <= '0;
      skid_bus   <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!skid_valid) begin
      if (out_tready || !out_valid) begin
        out_valid <= in_tvalid;
        if (in_tvalid) out_bus <= in_bus;
      end else if (in_tvalid) begin
        // Output is stalled but we advertised ready: park the beat.
        skid_bus   <= in_bus;
        skid_valid <= 1'b1;
      end
    end else if (out_tready) begin
      // Skid full implies output full; drain skid into output, upstream was held off.
      out_bus    <= skid_bus;
      skid_valid <= 1'b0;
    end
  end

  assign {out_tdata, out_tkeep, out_tlast, out_tuser, out_tid} = out_bus;
  assign out_tvalid = out_valid;

endmodule

// File: rtl/seg_rx_port_scheduler.sv
// rtl/seg_rx_port_scheduler.sv - frame-atomic round-robin merge of segmented RX ports
// Purpose: grants one enabled upstream port per frame in round-robin order and
// forwards its beats through a skid stage, counting frames and bad frames.
// Ports: clk/rst; s_axis_* per-port input streams (slice i = port i);
// port_enable per-port arbitration enable; m_axis_* merged stream with
// m_axis_tid = source port; frame_cnt/err_cnt per-port saturating counters.
module seg_rx_port_scheduler
  import seg_rx_port_scheduler_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 1024,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [N_PORTS-1:0]              s_axis_tvalid,
  input  logic [N_PORTS-1:0]              s_axis_tlast,
  input  logic [N_PORTS-1:0]              s_axis_tuser,
  output logic [N_PORTS-1:0]              s_axis_tready,
  input  logic [N_PORTS-1:0]              port_enable,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic [$clog2(N_PORTS)-1:0]      m_axis_tid,
  input  logic                            m_axis_tready,
  output logic [N_PORTS*CNT_WIDTH-1:0]    frame_cnt,
  output logic [N_PORTS*CNT_WIDTH-1:0]    err_cnt
);

  localparam int ID_W = $clog2(N_PORTS);

  sched_state_t    state;
  sched_state_t    state_next;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick;
  logic [N_PORTS-1:0] req;
  logic            sk_in_ready;
  logic            in_valid;
  logic            accept;
  logic            accept_last;

  logic [CNT_WIDTH-1:0] fcnt [N_PORTS];
  logic [CNT_WIDTH-1:0] ecnt [N_PORTS];

  assign req  = s_axis_tvalid & port_enable;
  assign pick = ID_W'(rr_pick(8'(req), 3'(rr_ptr), N_PORTS));

  // port_enable only gates who may win arbitration; a granted frame runs to tlast.
  assign in_valid    = (state == XFER) && s_axis_tvalid[grant];
  assign accept      = in_valid && sk_in_ready;
  assign accept_last = accept && s_axis_tlast[grant];

  always_comb begin
    state_next    = state;
    s_axis_tready = '0;
    case (state)
      IDLE: if (|req) state_next = XFER;
      XFER: begin
        s_axis_tready[grant] = sk_in_ready;
        if (accept_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && |req) grant <= pick;
      if (accept_last) rr_ptr <= (grant == ID_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PORTS; i++) begin
        fcnt[i] <= '0;
        ecnt[i] <= '0;
      end
    end else if (accept_last) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (grant == ID_W'(i)) begin
          if (fcnt[i] != '1) fcnt[i] <= fcnt[i] + 1'b1;
          if (s_axis_tuser[grant] && ecnt[i] != '1) ecnt[i] <= ecnt[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_cnt
    assign frame_cnt[g*CNT_WIDTH +: CNT_WIDTH] = fcnt[g];
    assign err_cnt[g*CNT_WIDTH +: CNT_WIDTH]   = ecnt[g];
  end

  seg_arb_skid #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH),
    .ID_WIDTH  (ID_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_tdata  (s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH]),
    .in_tkeep  (s_axis_tkeep[grant*KEEP_WIDTH +: KEEP_WIDTH]),
    .in_tlast  (s_axis_tlast[grant]),
    .in_tuser  (s_axis_tuser[grant]),
    .in_tid    (grant),
    .in_tvalid (in_valid),
    .in_tready (sk_in_ready),
    .out_tdata (m_axis_tdata),
    .out_tkeep (m_axis_tkeep),
    .out_tlast (m_axis_tlast),
    .out_tuser (m_axis_tuser),
    .out_tid   (m_axis_tid),
    .out_tvalid(m_axis_tvalid),
    .out_tready(m_axis_tready)
  );

endmodule

// File: tb/tb_seg_rx_port_scheduler.sv
// tb/tb_seg_rx_port_scheduler.sv - self-checking bench for seg_rx_port_scheduler
module tb_seg_rx_port_scheduler;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP-1:0]     s_tvalid, s_tlast, s_tuser, s_tready, port_enable;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid, m_tlast, m_tuser, m_tready;
  logic [1:0]        m_tid;
  logic [NP*CW-1:0]  frame_cnt, err_cnt;

  seg_rx_port_scheduler #(.N_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .port_enable(port_enable),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tid(m_tid),
    .m_axis_tready(m_tready),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  beat_t pq [NP][$];
  beat_t eq [NP][$];
  bit    first [NP];
  int    sent [NP];
  int    frames_left [NP];
  int    errs [NP];
  int    ptr_model, cyc, gap_pct, ready_mode, out_beats, cur_tid, t0, k;
  bit    rr_check, in_frame, held_v, last_out_user;
  logic [76:0] held;
  int    start_tid[$];
  int    start_cyc[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_expect();
    for (int j = 0; j < NP; j++) begin
      int idx = (ptr_model + j) % NP;
      if (frames_left[idx] > 0) return idx;
    end
    return -1;
  endfunction

  task automatic submit_frame(input int p, input int len, input bit user_last);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.data = {$urandom, $urandom};
      bt.keep = KW'($urandom);
      bt.last = (b == len - 1);
      bt.user = bt.last ? user_last : 1'b0;
      pq[p].push_back(bt);
      eq[p].push_back(bt);
    end
    frames_left[p]++;
    if (user_last) errs[p]++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NP; i++) begin
      if (pq[i].size() != 0 && (first[i] || $urandom_range(99) >= gap_pct)) begin
        beat_t b = pq[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[i*DW +: DW] = b.data;
        s_tkeep[i*KW +: KW] = b.keep;
        s_tlast[i] = b.last;
        s_tuser[i] = b.user;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tuser[i]  = 1'b0;
      end
    end
    case (ready_mode)
      1:       m_tready = (cyc % 2 == 0);
      2:       m_tready = 1'($urandom_range(1));
      default: m_tready = 1'b1;
    endcase
  endtask

  task automatic check_out();
    logic [76:0] cur;
    cur = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tid};
    if (held_v) chk("stall_hold", cur, held);
    held_v = m_tvalid && !m_tready;
    held = cur;
    if (m_tvalid && m_tready) begin
      int t = int'(m_tid);
      if (!in_frame) begin
        start_tid.push_back(t);
        start_cyc.push_back(cyc);
        if (rr_check) chk("rr_order", t, rr_expect());
        frames_left[t]--;
        ptr_model = (t + 1) % NP;
        in_frame = 1'b1;
        cur_tid = t;
      end else begin
        chk("tid_const", t, cur_tid);
      end
      chk("beat_expected", eq[t].size() != 0, 1);
      if (eq[t].size() != 0) begin
        beat_t e = eq[t].pop_front();
        chk("beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, e);
      end
      out_beats++;
      if (m_tlast) begin
        in_frame = 1'b0;
        last_out_user = m_tuser;
      end
    end
  endtask

  task automatic step();
    bit acc [NP];
    for (int i = 0; i < NP; i++) acc[i] = s_tvalid[i] && s_tready[i];
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) begin
        beat_t b = pq[i].pop_front();
        sent[i]++;
        first[i] = b.last;
      end
    end
    drive_inputs();
    check_out();
  endtask

  task automatic run_beats(input int n, input int budget, input string tag);
    int j = 0;
    while (out_beats < n && j < budget) begin
      step();
      j++;
    end
    chk({tag, "_done"}, out_beats >= n, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NP; i++) begin
      pq[i].delete();
      eq[i].delete();
      first[i] = 1'b1;
      sent[i] = 0;
      frames_left[i] = 0;
      errs[i] = 0;
    end
    start_tid.delete();
    start_cyc.delete();
    ptr_model = 0; in_frame = 0; held_v = 0; out_beats = 0;
    gap_pct = 0; ready_mode = 0; rr_check = 1;
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0; s_tkeep = '0;
    port_enable = '1; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    cyc = 0;
    rst = 1'b1;
    port_enable = '1; m_tready = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0; s_tkeep = '0;
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_bus", {m_tdata, m_tkeep, m_tlast, m_tuser, m_tid}, 0);
    chk("rst_counters", {frame_cnt, err_cnt}, 0);

    // Four simultaneous 3-beat frames: tid order 0..3, one bubble between frames.
    do_reset();
    for (int p = 0; p < NP; p++) submit_frame(p, 3, 1'b0);
    drive_inputs();
    t0 = cyc;
    run_beats(12, 100, "t1");
    chk("t1_frames", start_tid.size(), 4);
    if (start_tid.size() == 4) begin
      for (int f = 0; f < 4; f++) chk("t1_tid", start_tid[f], f);
      chk("t1_latency", start_cyc[0] - t0, 2);
      for (int f = 0; f < 3; f++) chk("t1_bubble", start_cyc[f+1] - start_cyc[f], 4);
    end
    for (int p = 0; p < NP; p++) chk("t1_frame_cnt", frame_cnt[p*CW +: CW], 1);

    // Port 2 alone after rr_ptr has moved to 3: wrap-around grant, 2-cycle latency.
    do_reset();
    submit_frame(2, 2, 1'b0);
    drive_inputs();
    run_beats(2, 50, "t2a");
    repeat (3) step();
    start_tid.delete();
    start_cyc.delete();
    submit_frame(2, 1, 1'b0);
    drive_inputs();
    t0 = cyc;
    run_beats(3, 50, "t2b");
    chk("t2_frames", start_tid.size(), 1);
    if (start_tid.size() == 1) begin
      chk("t2_tid", start_tid[0], 2);
      chk("t2_latency", start_cyc[0] - t0, 2);
    end

    // Port 1 8-beat frame with m_axis_tready toggling every cycle.
    do_reset();
    ready_mode = 1;
    submit_frame(1, 8, 1'b0);
    drive_inputs();
    run_beats(8, 100, "t3");
    repeat (3) step();
    chk("t3_beats", out_beats, 8);
    chk("t3_drained", eq[1].size(), 0);

    // Disable port 0 mid-frame while port 1 waits.
    do_reset();
    rr_check = 0;
    submit_frame(0, 5, 1'b0);
    submit_frame(0, 1, 1'b0);
    submit_frame(1, 2, 1'b0);
    drive_inputs();
    k = 0;
    while (sent[0] < 2 && k < 50) begin
      step();
      k++;
    end
    chk("t4_beat2_seen", sent[0] >= 2, 1);
    port_enable[0] = 1'b0;
    repeat (40) step();
    chk("t4_frames", start_tid.size(), 2);
    if (start_tid.size() == 2) begin
      chk("t4_first", start_tid[0], 0);
      chk("t4_second", start_tid[1], 1);
    end
    chk("t4_beats", out_beats, 7);
    chk("t4_port0_held_off", pq[0].size(), 1);

    // Bad frame on port 3, then saturation of both counters.
    do_reset();
    submit_frame(3, 2, 1'b1);
    drive_inputs();
    run_beats(2, 50, "t5a");
    chk("t5_user", last_out_user, 1);
    chk("t5_err_cnt", err_cnt[3*CW +: CW], 1);
    chk("t5_frame_cnt", frame_cnt[3*CW +: CW], 1);
    chk("t5_err_cnt0", err_cnt[0 +: CW], 0);
    for (int f = 0; f < 16; f++) submit_frame(3, 1, 1'b1);
    drive_inputs();
    run_beats(18, 200, "t5b");
    chk("t5_frame_sat", frame_cnt[3*CW +: CW], 4'hf);
    chk("t5_err_sat", err_cnt[3*CW +: CW], 4'hf);

    // Reset mid-frame: immediate clear, fresh arbitration from pointer 0.
    do_reset();
    rr_check = 0;
    submit_frame(1, 1, 1'b0);
    drive_inputs();
    run_beats(1, 50, "t6a");
    repeat (2) step();
    chk("t6_pre_cnt", frame_cnt[1*CW +: CW], 1);
    submit_frame(0, 5, 1'b0);
    drive_inputs();
    k = 0;
    while (sent[0] < 3 && k < 50) begin
      step();
      k++;
    end
    rst = 1'b1;
    #1;
    chk("t6_m_tvalid", m_tvalid, 0);
    chk("t6_s_tready", s_tready, 0);
    chk("t6_m_bus", {m_tdata, m_tkeep, m_tlast, m_tuser, m_tid}, 0);
    chk("t6_counters", {frame_cnt, err_cnt}, 0);
    do_reset();
    submit_frame(3, 1, 1'b0);
    submit_frame(1, 1, 1'b0);
    drive_inputs();
    run_beats(2, 50, "t6b");
    if (start_tid.size() != 0) chk("t6_fresh_ptr", start_tid[0], 1);

    // Randomised traffic: mid-frame valid gaps, random downstream stalls.
    do_reset();
    gap_pct = 25;
    ready_mode = 2;
    k = 0;
    for (int p = 0; p < NP; p++) begin
      for (int f = 0; f < 3; f++) begin
        int len = int'($urandom_range(6, 1));
        submit_frame(p, len, 1'($urandom_range(1)));
        k += len;
      end
    end
    drive_inputs();
    run_beats(k, 3000, "t7");
    for (int p = 0; p < NP; p++) begin
      chk("t7_frame_cnt", frame_cnt[p*CW +: CW], 3);
      chk("t7_err_cnt", err_cnt[p*CW +: CW], errs[p]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
